// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the UART RX frame controller, its sampler and the
// downstream consumer. The slave side is the frame controller itself; the
// master side is whatever drives the serial line, config and the sampler vote.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  sampled_bit;
    logic                  sample_en;
    logic [4:0]            edge_count;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        output sample_en, edge_count, P_DATA, data_valid, par_err, stp_err, busy
    );

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  sample_en, edge_count, P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receiver frame controller: start detection, bit timing for the
// majority-vote sampler, LSB-first deserialisation, parity/stop checking.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low; strobe cycle of the last frame
// START  | timing the start bit; false start if it votes high
// DATA   | shifting in DATA_WIDTH data bits, LSB first
// PARITY | checking the parity bit against the received word
// STOP   | checking the stop bit, then publishing the frame
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [5:0]            prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [4:0]            edge_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_mis_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic                  cfg_load;
    logic                  shift_en;
    logic                  par_chk;
    logic                  frame_done;

    logic [5:0]            prescale_m1;
    logic                  bit_end;
    logic                  presc_ok;
    logic                  last_bit;
    logic                  par_exp;
    logic                  stp;

    // Prescale of 32 wraps to 0 in the low five bits, so 0-1 gives 31 as needed.
    assign prescale_m1 = prescale_q - 6'd1;
    assign bit_end     = (edge_cnt == prescale_m1[4:0]);
    assign presc_ok    = (prescale_q == 6'd8) || (prescale_q == 6'd16) || (prescale_q == 6'd32);
    assign last_bit    = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign par_exp     = par_typ_q ? ~^shift_q : ^shift_q;
    assign stp         = ~bus.sampled_bit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        state_nxt  = state;
        cfg_load   = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_nxt = START;
                    cfg_load  = 1'b1;
                end
            end
            START: begin
                // An illegal ratio cannot time the bit, so drop the frame at once.
                if (!presc_ok)    state_nxt = IDLE;
                else if (bit_end) state_nxt = bus.sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame configuration is frozen at the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= 6'd0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else if (cfg_load) begin
            prescale_q <= bus.Prescale;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
        end
    end

    // Position within the current bit; parked at 0 whenever the line is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     edge_cnt <= 5'd0;
        else if (state == IDLE || state_nxt == IDLE || bit_end) edge_cnt <= 5'd0;
        else                                            edge_cnt <= edge_cnt + 5'd1;
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q[bit_idx] <= bus.sampled_bit;
            bit_idx          <= last_bit ? '0 : bit_idx + 1'b1;
        end else if (state != DATA) begin
            bit_idx <= '0;
        end
    end

    // Parity mismatch flag, cleared per frame so unparitied frames report none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        par_mis_q <= 1'b0;
        else if (cfg_load) par_mis_q <= 1'b0;
        else if (par_chk)  par_mis_q <= (bus.sampled_bit != par_exp);
    end

    // Publish word and single-cycle status strobes on the stop-bit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (frame_done) begin
                p_data_q     <= shift_q;
                data_valid_q <= ~stp & ~par_mis_q;
                par_err_q    <= par_mis_q;
                stp_err_q    <= stp;
            end
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.sample_en  = (state != IDLE);
    assign bus.edge_count = edge_cnt;
    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for the UART RX frame controller with a mid-bit sampler model.
module tb_uart_rx_frame_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   cur_p;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sampler model: takes the line at mid-bit, settled well before Prescale-1.
    always @(posedge clk) begin
        if (bus.sample_en && bus.edge_count == 5'(cur_p / 2))
            bus.sampled_bit <= bus.RX_IN;
    end

    // Strobe monitor, cumulative counts.
    int          dv_cnt, pe_cnt, se_cnt, dv_cyc;
    logic [7:0]  dv_data_last, dv_data_prev;
    logic        prev_dv, busy_after_dv;
    initial begin
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0; dv_cyc = 0;
        dv_data_last = 8'h00; dv_data_prev = 8'h00;
        prev_dv = 1'b0; busy_after_dv = 1'b0;
    end
    always @(negedge clk) begin
        if (prev_dv) busy_after_dv = bus.busy;
        prev_dv = bus.data_valid;
        if (bus.data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
            dv_data_prev = dv_data_last;
            dv_data_last = bus.P_DATA;
        end
        if (bus.par_err) pe_cnt++;
        if (bus.stp_err) se_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    // Drives one frame at p clocks per bit; must be called just after a posedge.
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                              input logic par_bit, input logic stop_bit, output int fall_cyc);
        logic bits [11];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        n = 9;
        if (par_en) begin
            bits[n] = par_bit;
            n++;
        end
        bits[n] = stop_bit;
        n++;
        fall_cyc = cyc;
        for (int b = 0; b < n; b++) begin
            bus.RX_IN = bits[b];
            repeat (p) @(posedge clk);
            #1;
        end
        bus.RX_IN = 1'b1;
    endtask

    int f0, f1, d0, p0, s0;

    initial begin
        checks = 0; failures = 0; cyc = 0; cur_p = 8;
        bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        bus.sampled_bit = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    32'(bus.busy), 32'd0);
        chk("rst_sample",  32'(bus.sample_en), 32'd0);
        chk("rst_edge",    32'(bus.edge_count), 32'd0);
        chk("rst_pdata",   32'(bus.P_DATA), 32'd0);
        chk("rst_strobes", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
        rst_n = 1'b1;
        sync();

        // P=8 even parity 0xA5 (four ones -> parity bit 0); config changed mid-frame.
        cur_p = 8; bus.Prescale = 6'd8; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        fork
            send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, f0);
            begin
                repeat (20) @(posedge clk);
                #2;
                bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b1; bus.Prescale = 6'd16;
            end
        join
        repeat (4) sync();
        chk("t1_dv_cnt",  32'(dv_cnt - d0), 32'd1);
        chk("t1_pe_cnt",  32'(pe_cnt - p0), 32'd0);
        chk("t1_se_cnt",  32'(se_cnt - s0), 32'd0);
        chk("t1_pdata",   32'(bus.P_DATA), 32'hA5);
        chk("t1_latency", 32'(dv_cyc - f0), 32'(8 * 11 + 1));
        chk("t1_busy",    32'(bus.busy), 32'd0);

        // P=16 no parity, back-to-back 0x3C then 0xC3 with no idle gap on the line.
        cur_p = 16; bus.Prescale = 6'd16; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        d0 = dv_cnt;
        sync();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, f0);
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, f1);
        repeat (4) sync();
        chk("t2_dv_cnt",    32'(dv_cnt - d0), 32'd2);
        chk("t2_data0",     32'(dv_data_prev), 32'h3C);
        chk("t2_data1",     32'(dv_data_last), 32'hC3);
        chk("t2_no_gap",    32'(busy_after_dv), 32'd0);
        chk("t2_pdata",     32'(bus.P_DATA), 32'hC3);

        // P=32 odd parity, 0x01 with parity bit 1 (expected 0) -> parity error.
        cur_p = 32; bus.Prescale = 6'd32; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        sync();
        send_frame(8'h01, 32, 1'b1, 1'b1, 1'b1, f0);
        repeat (4) sync();
        chk("t3_pe_cnt", 32'(pe_cnt - p0), 32'd1);
        chk("t3_dv_cnt", 32'(dv_cnt - d0), 32'd0);
        chk("t3_se_cnt", 32'(se_cnt - s0), 32'd0);
        chk("t3_pdata",  32'(bus.P_DATA), 32'h01);

        // P=8 no parity, 0xFF with stop bit 0 -> stop error.
        cur_p = 8; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        sync();
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, f0);
        repeat (4) sync();
        chk("t4_se_cnt", 32'(se_cnt - s0), 32'd1);
        chk("t4_dv_cnt", 32'(dv_cnt - d0), 32'd0);
        chk("t4_pe_cnt", 32'(pe_cnt - p0), 32'd0);
        chk("t4_pdata",  32'(bus.P_DATA), 32'hFF);

        // P=16 glitch: low 4 clocks, then high -> false start after one bit time.
        cur_p = 16; bus.Prescale = 6'd16;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        sync();
        bus.RX_IN = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.RX_IN = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t5_busy_in_start", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy_after", 32'(bus.busy), 32'd0);
        repeat (4) sync();
        chk("t5_strobes", 32'((dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);

        // Illegal Prescale=10 latched at start -> no frame, no strobes.
        cur_p = 10; bus.Prescale = 6'd10;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        sync();
        bus.RX_IN = 1'b0;
        repeat (5) sync();
        bus.RX_IN = 1'b1;
        repeat (5) sync();
        chk("t6_busy",    32'(bus.busy), 32'd0);
        chk("t6_strobes", 32'((dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);

        // Reset during DATA bit 3 at P=8, then a clean 0x5A frame.
        cur_p = 8; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0;
        sync();
        bus.RX_IN = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.RX_IN = 1'b0;
        repeat (8 * 3 + 3) @(posedge clk);
        #2;
        chk("t7_busy_pre", 32'(bus.busy), 32'd1);
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_busy",  32'(bus.busy), 32'd0);
        chk("t7_rst_edge",  32'(bus.edge_count), 32'd0);
        chk("t7_rst_pdata", 32'(bus.P_DATA), 32'd0);
        chk("t7_rst_dv",    32'(bus.data_valid), 32'd0);
        bus.RX_IN = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) sync();
        chk("t7_no_strobe", 32'((dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);
        d0 = dv_cnt;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, f0);
        repeat (4) sync();
        chk("t7_dv_cnt",  32'(dv_cnt - d0), 32'd1);
        chk("t7_pdata",   32'(bus.P_DATA), 32'h5A);
        chk("t7_latency", 32'(dv_cyc - f0), 32'(8 * 10 + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
